// File: rtl/dm9000_burst_bus_engine.sv
// DM9000a bus engine: per command, one index write followed by 0..N read or write
// data beats, with parameterised setup/strobe/recovery timing and a post-command delay.
module dm9000_burst_bus_engine #(
  parameter int DATA_W      = 16,
  parameter int LEN_W       = 11,
  parameter int DLY_W       = 16,
  parameter int SETUP_CYC   = 1,
  parameter int STROBE_CYC  = 1,
  parameter int RECOVER_CYC = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [7:0]        cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DLY_W-1:0]  cmd_delay,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  input  logic [DATA_W-1:0] ENET_DATAr,
  input  logic              ENET_INT,
  output logic [DATA_W-1:0] ENET_DATAw,
  output logic              Drive_ENET_DATA,
  output logic              ENET_CMD,
  output logic              ENET_CS_N,
  output logic              ENET_WR_N,
  output logic              ENET_RD_N,
  output logic              ENET_RST_N,
  output logic              ENET_CLK,
  output logic              interrupt_out
);

  localparam int MAX_SS = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_C  = (MAX_SS > RECOVER_CYC) ? MAX_SS : RECOVER_CYC;
  localparam int PH_W   = $clog2(MAX_C) + 1;
  localparam logic [PH_W-1:0] SETUP_LD = PH_W'(SETUP_CYC - 1);
  localparam logic [PH_W-1:0] STRB_LD  = PH_W'(STROBE_CYC - 1);
  localparam logic [PH_W-1:0] REC_LD   = PH_W'(RECOVER_CYC - 1);

  typedef enum logic [3:0] {
    IDLE, IDX_SETUP, IDX_STROBE, IDX_RECOVER, WAIT_WR,
    DAT_SETUP, DAT_STROBE, DAT_RECOVER, DELAY, DONE
  } state_t;

  typedef struct packed {
    logic              cs_n;
    logic              cmd;
    logic              wr_n;
    logic              rd_n;
    logic              drive;
    logic [DATA_W-1:0] dataw;
    logic              cmd_ready;
    logic              wr_ready;
    logic              done;
  } pins_t;

  localparam pins_t PINS_RST = '{cs_n: 1'b1, cmd: 1'b0, wr_n: 1'b1, rd_n: 1'b1,
                                 drive: 1'b0, dataw: '0, cmd_ready: 1'b1,
                                 wr_ready: 1'b0, done: 1'b0};

  state_t            state, state_n;
  logic [PH_W-1:0]   ph, ph_n;
  logic [LEN_W-1:0]  beats, beats_n;
  logic [DLY_W-1:0]  dly, dly_n, dly_q;
  logic [DATA_W-1:0] word_q, word_n;
  logic [7:0]        addr_q, addr_n;
  logic              wr_q, wr_sel_n;
  logic              accept, rd_smp;
  logic [1:0]        int_s;
  pins_t             pins_q, pins_n;
  state_t            tail_st;

  assign accept   = (state == IDLE) && cmd_valid;
  assign addr_n   = accept ? cmd_addr : addr_q;
  assign wr_sel_n = accept ? cmd_write : wr_q;
  assign tail_st  = (dly_q == '0) ? DONE : DELAY;
  assign rd_smp   = (state == DAT_STROBE) && (ph == '0) && !wr_q;

  // Sequencing: every timed state leaves when its shared phase counter hits zero.
  always_comb begin
    state_n = state;
    ph_n    = ph;
    beats_n = beats;
    dly_n   = dly;
    word_n  = word_q;
    case (state)
      IDLE: if (cmd_valid) begin
        state_n = IDX_SETUP;
        ph_n    = SETUP_LD;
        beats_n = cmd_len;
      end
      IDX_SETUP: if (ph == '0) begin
        state_n = IDX_STROBE;
        ph_n    = STRB_LD;
      end else ph_n = ph - PH_W'(1);
      IDX_STROBE: if (ph == '0) begin
        state_n = IDX_RECOVER;
        ph_n    = REC_LD;
      end else ph_n = ph - PH_W'(1);
      IDX_RECOVER: if (ph == '0) begin
        if (beats == '0) begin
          state_n = tail_st;
          dly_n   = dly_q - DLY_W'(1);
        end else if (wr_q) state_n = WAIT_WR;
        else begin
          state_n = DAT_SETUP;
          ph_n    = SETUP_LD;
        end
      end else ph_n = ph - PH_W'(1);
      WAIT_WR: if (wr_valid) begin
        word_n  = wr_data;
        state_n = DAT_SETUP;
        ph_n    = SETUP_LD;
      end
      DAT_SETUP: if (ph == '0) begin
        state_n = DAT_STROBE;
        ph_n    = STRB_LD;
      end else ph_n = ph - PH_W'(1);
      DAT_STROBE: if (ph == '0) begin
        state_n = DAT_RECOVER;
        ph_n    = REC_LD;
      end else ph_n = ph - PH_W'(1);
      DAT_RECOVER: if (ph == '0) begin
        beats_n = beats - LEN_W'(1);
        if (beats != LEN_W'(1)) begin
          state_n = wr_q ? WAIT_WR : DAT_SETUP;
          ph_n    = SETUP_LD;
        end else begin
          state_n = tail_st;
          dly_n   = dly_q - DLY_W'(1);
        end
      end else ph_n = ph - PH_W'(1);
      DELAY: if (dly == '0) state_n = DONE;
             else dly_n = dly - DLY_W'(1);
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Pin image of the next state, registered so the pins track the state exactly.
  always_comb begin
    pins_n           = PINS_RST;
    pins_n.cmd_ready = 1'b0;
    pins_n.dataw     = pins_q.dataw;
    case (state_n)
      IDLE: pins_n.cmd_ready = 1'b1;
      IDX_SETUP, IDX_STROBE: begin
        pins_n.cs_n  = 1'b0;
        pins_n.drive = 1'b1;
        pins_n.dataw = DATA_W'(addr_n);
        pins_n.wr_n  = (state_n != IDX_STROBE);
      end
      IDX_RECOVER: pins_n.cs_n = 1'b0;
      WAIT_WR: begin
        pins_n.cs_n     = 1'b0;
        pins_n.cmd      = 1'b1;
        pins_n.wr_ready = 1'b1;
      end
      DAT_SETUP, DAT_STROBE: begin
        pins_n.cs_n  = 1'b0;
        pins_n.cmd   = 1'b1;
        pins_n.drive = wr_sel_n;
        if (wr_sel_n) pins_n.dataw = word_n;
        if (state_n == DAT_STROBE) begin
          pins_n.wr_n = !wr_sel_n;
          pins_n.rd_n = wr_sel_n;
        end
      end
      DAT_RECOVER: begin
        pins_n.cs_n = 1'b0;
        pins_n.cmd  = 1'b1;
      end
      DONE: pins_n.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      ph       <= '0;
      beats    <= '0;
      dly      <= '0;
      dly_q    <= '0;
      word_q   <= '0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      pins_q   <= PINS_RST;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      int_s    <= 2'b00;
    end else begin
      state    <= state_n;
      ph       <= ph_n;
      beats    <= beats_n;
      dly      <= dly_n;
      word_q   <= word_n;
      pins_q   <= pins_n;
      rd_valid <= rd_smp;
      int_s    <= {int_s[0], ENET_INT};
      if (rd_smp) rd_data <= ENET_DATAr;
      if (accept) begin
        wr_q   <= cmd_write;
        addr_q <= cmd_addr;
        dly_q  <= cmd_delay;
      end
    end
  end

  assign cmd_ready       = pins_q.cmd_ready;
  assign wr_ready        = pins_q.wr_ready;
  assign done            = pins_q.done;
  assign ENET_DATAw      = pins_q.dataw;
  assign Drive_ENET_DATA = pins_q.drive;
  assign ENET_CMD        = pins_q.cmd;
  assign ENET_CS_N       = pins_q.cs_n;
  assign ENET_WR_N       = pins_q.wr_n;
  assign ENET_RD_N       = pins_q.rd_n;
  assign ENET_RST_N      = 1'b1;
  assign ENET_CLK        = Clock;
  assign interrupt_out   = int_s[1];

endmodule

// File: tb/tb_dm9000_burst_bus_engine.sv
// Directed bench for dm9000_burst_bus_engine: default-timing instance plus a
// slow-timing (2/3/1) instance, with scoreboards for strobed words and read beats.
module tb_dm9000_burst_bus_engine;
  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  logic        cmd_valid, cmd_ready, cmd_write, wr_valid, wr_ready, rd_valid, done;
  logic [7:0]  cmd_addr;
  logic [10:0] cmd_len;
  logic [15:0] cmd_delay, wr_data, rd_data, ENET_DATAr, ENET_DATAw;
  logic        ENET_INT, Drive_ENET_DATA, ENET_CMD, ENET_CS_N, ENET_WR_N, ENET_RD_N;
  logic        ENET_RST_N, ENET_CLK, interrupt_out;

  logic        b_cmd_valid, b_cmd_ready, b_wr_ready, b_rd_valid, b_done;
  logic [15:0] b_rd_data, b_DATAr, b_DATAw;
  logic        b_Drive, b_CMD, b_CS_N, b_WR_N, b_RD_N, b_RST_N, b_CLK, b_int;

  dm9000_burst_bus_engine dut (
    .Clock(Clock), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_delay(cmd_delay),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data),
    .rd_valid(rd_valid), .done(done), .ENET_DATAr(ENET_DATAr), .ENET_INT(ENET_INT),
    .ENET_DATAw(ENET_DATAw), .Drive_ENET_DATA(Drive_ENET_DATA), .ENET_CMD(ENET_CMD),
    .ENET_CS_N(ENET_CS_N), .ENET_WR_N(ENET_WR_N), .ENET_RD_N(ENET_RD_N),
    .ENET_RST_N(ENET_RST_N), .ENET_CLK(ENET_CLK), .interrupt_out(interrupt_out));

  dm9000_burst_bus_engine #(.SETUP_CYC(2), .STROBE_CYC(3), .RECOVER_CYC(1)) dut2 (
    .Clock(Clock), .Reset(Reset), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_write(1'b0), .cmd_addr(8'h44), .cmd_len(11'd3), .cmd_delay(16'd0),
    .wr_data(16'h0000), .wr_valid(1'b0), .wr_ready(b_wr_ready), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .done(b_done), .ENET_DATAr(b_DATAr), .ENET_INT(1'b0),
    .ENET_DATAw(b_DATAw), .Drive_ENET_DATA(b_Drive), .ENET_CMD(b_CMD),
    .ENET_CS_N(b_CS_N), .ENET_WR_N(b_WR_N), .ENET_RD_N(b_RD_N),
    .ENET_RST_N(b_RST_N), .ENET_CLK(b_CLK), .interrupt_out(b_int));

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  logic [16:0] exp_wq[$];   // {CMD, DATAw} expected at each WR_N falling edge
  logic [15:0] exp_rq[$];
  logic [15:0] b_rq[$];
  int n_idx = 0, n_dat_wr = 0, n_dat_rd = 0, last_idx_cyc = 0, done_cyc = 0;
  int b_pulses = 0, b_rv = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag, input int sz);
    checks++;
    assert (sz != 0) else begin
      errors++;
      $error("FAIL %s: observed empty scoreboard expected a pending entry", tag);
    end
  endtask

  // Scoreboard side for the default-timing instance.
  initial begin
    logic prev_wr_n, prev_rd_n;
    prev_wr_n = 1'b1;
    prev_rd_n = 1'b1;
    forever begin
      @(negedge Clock);
      if (!Reset) begin
        if (!ENET_WR_N && prev_wr_n) begin
          if (ENET_CMD) n_dat_wr++;
          else begin n_idx++; last_idx_cyc = cyc; end
          chk_pop("strobe_sb", exp_wq.size());
          if (exp_wq.size() != 0) chk("strobe_word", {ENET_CMD, ENET_DATAw}, exp_wq.pop_front());
        end
        if (!ENET_RD_N && prev_rd_n) n_dat_rd++;
        if (rd_valid) begin
          chk_pop("rd_sb", exp_rq.size());
          if (exp_rq.size() != 0) chk("rd_data", rd_data, exp_rq.pop_front());
        end
        if (done) done_cyc = cyc;
        if (wr_ready)
          chk("wr_ready_scope", {ENET_WR_N, ENET_RD_N, done, cmd_ready, ENET_CS_N}, 5'b11000);
      end
      prev_wr_n = ENET_WR_N;
      prev_rd_n = ENET_RD_N;
    end
  end

  // Slow-timing instance: strobe width, setup before strobe, per-beat read data.
  initial begin
    logic prev_rd_n;
    logic [1:0] hist;
    int run;
    prev_rd_n = 1'b1; hist = 2'b00; run = 0;
    b_DATAr = 16'hB000;
    forever begin
      @(negedge Clock);
      if (!Reset) begin
        if (!b_RD_N) begin
          if (prev_rd_n) chk("b_setup_before_strobe", hist, 2'b11);
          run++;
        end else if (!prev_rd_n) begin
          chk("b_strobe_len", run, 3);
          run = 0;
          b_pulses++;
          b_DATAr = 16'hB000 + 16'(b_pulses);
        end
        if (b_rd_valid) begin
          b_rv++;
          chk_pop("b_rd_sb", b_rq.size());
          if (b_rq.size() != 0) chk("b_rd_data", b_rd_data, b_rq.pop_front());
        end
      end
      hist = {hist[0], b_CMD && !b_CS_N && b_RD_N && !b_Drive};
      prev_rd_n = b_RD_N;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic wr, input logic [7:0] a, input logic [10:0] len,
                       input logic [15:0] dly);
    @(posedge Clock); #1;
    cmd_write = wr; cmd_addr = a; cmd_len = len; cmd_delay = dly; cmd_valid = 1'b1;
    exp_wq.push_back({1'b0, 8'h00, a});
  endtask

  task automatic wait_done(input string tag);
    int w;
    w = 0;
    @(negedge Clock);
    while (!done && w < 2000) begin @(negedge Clock); w++; end
    chk(tag, done, 1'b1);
  endtask

  initial begin
    logic [15:0] words[4];
    int base_i, base_w, base_r, w, t_idx;
    words[0] = 16'h1234; words[1] = 16'h5678; words[2] = 16'h9ABC; words[3] = 16'hDEF0;
    Reset = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_delay = 0;
    wr_data = 0; wr_valid = 0; ENET_DATAr = 0; ENET_INT = 0; b_cmd_valid = 0;
    repeat (3) @(negedge Clock);
    chk("rst_strobes", {ENET_WR_N, ENET_RD_N, ENET_CS_N, ENET_CMD, Drive_ENET_DATA}, 5'b11100);
    chk("rst_dataw", ENET_DATAw, 16'h0000);
    chk("rst_status", {cmd_ready, wr_ready, rd_valid, done, interrupt_out}, 5'b10000);
    chk("rst_rd_data", rd_data, 16'h0000);
    chk("rst_n_clk", {ENET_RST_N, ENET_CLK}, {1'b1, Clock});
    @(posedge Clock); #1 Reset = 1'b0;

    // Single read beat: cycle-accurate latency
    ENET_DATAr = 16'h0A46;
    issue(1'b0, 8'h28, 11'd1, 16'd0);
    exp_rq.push_back(16'h0A46);
    @(negedge Clock);
    chk("rd_accept_ready", cmd_ready, 1'b1);
    @(posedge Clock); #1 cmd_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge Clock);
      chk($sformatf("rd_wr_n_c%0d", k), ENET_WR_N, k != 2);
      chk($sformatf("rd_rd_n_c%0d", k), ENET_RD_N, k != 6);
      chk($sformatf("rd_valid_c%0d", k), rd_valid, k == 7);
      chk($sformatf("rd_done_c%0d", k), done, k == 9);
      chk($sformatf("rd_ready_c%0d", k), cmd_ready, k == 10);
    end

    // Write burst of 4 with a 5-cycle stall before beat 3
    base_i = n_idx; base_w = n_dat_wr;
    issue(1'b1, 8'hF8, 11'd4, 16'd0);
    @(posedge Clock); #1 cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w = 0;
      @(negedge Clock);
      while (!wr_ready && w < 100) begin @(negedge Clock); w++; end
      chk("wr_ready_wait", wr_ready, 1'b1);
      if (i == 2)
        repeat (5) begin
          @(negedge Clock);
          chk("stall_no_strobe", {ENET_WR_N, wr_ready}, 2'b11);
        end
      wr_data = words[i]; wr_valid = 1'b1;
      exp_wq.push_back({1'b1, words[i]});
      @(posedge Clock); #1 wr_valid = 1'b0;
    end
    wait_done("wr_done");
    chk("wr_data_pulses", n_dat_wr - base_w, 4);
    chk("wr_idx_pulses", n_idx - base_i, 1);

    // Index-only command with a 300-cycle tail delay
    base_w = n_dat_wr; base_r = n_dat_rd;
    @(negedge Clock);
    issue(1'b1, 8'h5A, 11'd0, 16'd300);
    @(posedge Clock); #1 cmd_valid = 1'b0;
    wait_done("idx_done");
    t_idx = last_idx_cyc;
    chk("idx_delay_span", done_cyc - t_idx, 303);
    chk("idx_no_data", (n_dat_wr - base_w) + (n_dat_rd - base_r), 0);
    @(negedge Clock);
    chk("idx_done_pulse", {done, cmd_ready}, 2'b01);

    // cmd_valid held while busy is taken only in the cycle after done
    issue(1'b1, 8'h11, 11'd0, 16'd0);
    @(negedge Clock);
    chk("busy_accept0", cmd_ready, 1'b1);
    @(posedge Clock); #1 cmd_addr = 8'h22;
    exp_wq.push_back({1'b0, 16'h0022});
    for (int k = 1; k <= 7; k++) begin
      @(negedge Clock);
      chk($sformatf("busy_ready_c%0d", k), cmd_ready, k == 6);
      chk($sformatf("busy_done_c%0d", k), done, k == 5);
    end
    cmd_valid = 1'b0;
    wait_done("busy_done2");

    // Interrupt synchroniser
    @(posedge Clock); #1 ENET_INT = 1'b1;
    @(negedge Clock); chk("int_c0", interrupt_out, 1'b0);
    @(posedge Clock); #1 ENET_INT = 1'b0;
    @(negedge Clock); chk("int_c1", interrupt_out, 1'b0);
    @(negedge Clock); chk("int_c2", interrupt_out, 1'b1);
    @(negedge Clock); chk("int_c3", interrupt_out, 1'b0);

    // Asynchronous reset in the middle of a write data strobe
    issue(1'b1, 8'h33, 11'd1, 16'd0);
    wr_data = 16'h4444; wr_valid = 1'b1;
    exp_wq.push_back({1'b1, 16'h4444});
    @(posedge Clock); #1 cmd_valid = 1'b0;
    w = 0;
    @(negedge Clock);
    while (!(!ENET_WR_N && ENET_CMD) && w < 50) begin @(negedge Clock); w++; end
    chk("rst_mid_reached", {ENET_WR_N, ENET_CMD}, 2'b01);
    #2 Reset = 1'b1;
    #1;
    chk("rst_mid_pins", {ENET_WR_N, ENET_CS_N, Drive_ENET_DATA}, 3'b110);
    wr_valid = 1'b0;
    @(posedge Clock); #1 Reset = 1'b0;
    @(negedge Clock);
    chk("rst_mid_after", {cmd_ready, ENET_WR_N, ENET_CS_N, done}, 4'b1110);

    // Slow-timing read burst of 3
    b_rq.push_back(16'hB000); b_rq.push_back(16'hB001); b_rq.push_back(16'hB002);
    @(posedge Clock); #1 b_cmd_valid = 1'b1;
    @(posedge Clock); #1 b_cmd_valid = 1'b0;
    w = 0;
    @(negedge Clock);
    while (!b_done && w < 200) begin @(negedge Clock); w++; end
    chk("b_done", b_done, 1'b1);
    chk("b_pulses", b_pulses, 3);
    chk("b_rd_valid_count", b_rv, 3);

    chk("sb_wq_drained", exp_wq.size(), 0);
    chk("sb_rq_drained", exp_rq.size() + b_rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm9000_burst_bus_engine.md
Name: dm9000_burst_bus_engine

Overview:
- Parametrised successor to the DM9000a register-access controller.
- Executes one command per handshake: an index (address) write, then 0..N data beats (read or write).
- Timing per beat is set by parameters; an explicit post-command delay is programmed per command.
- Sits between the arbitrator and the DM9000a pins.
- Replaces the "hold command_type to keep looping" TX/RX burst scheme with an explicit beat count and ready/valid data streams.

Parameters:
- DATA_W, 16, bus width in bits (8 or 16); the index is zero-extended to DATA_W.
- LEN_W, 11, width of the beat count (max 2047 beats per command).
- DLY_W, 16, width of the post-command delay counter.
- SETUP_CYC, 1, cycles data/CMD are driven before the strobe (>=1).
- STROBE_CYC, 1, cycles WR_N/RD_N are held low (>=1).
- RECOVER_CYC, 2, idle cycles after every strobe (>=1).

Ports:
- Clock  in  1  system clock; also driven out on ENET_CLK.
- Reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine idle; the command is accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = data beats are writes, 0 = reads.
- cmd_addr  in  8  DM9000a register index.
- cmd_len  in  LEN_W  number of data beats; 0 = index write only.
- cmd_delay  in  DLY_W  idle cycles inserted after the last recovery, before done.
- wr_data  in  DATA_W  write beat data.
- wr_valid  in  1  write beat available.
- wr_ready  out  1  beat consumed when wr_valid && wr_ready.
- rd_data  out  DATA_W  captured read beat.
- rd_valid  out  1  one-cycle pulse per read beat; no backpressure.
- done  out  1  one-cycle pulse when a command completes.
- ENET_DATAr  in  DATA_W  data from the chip.
- ENET_INT  in  1  chip interrupt.
- ENET_DATAw  out  DATA_W  data to the chip.
- Drive_ENET_DATA  out  1  tristate enable for ENET_DATAw.
- ENET_CMD  out  1  0 = index, 1 = data.
- ENET_CS_N  out  1  chip select, active low.
- ENET_WR_N  out  1  write strobe, active low.
- ENET_RD_N  out  1  read strobe, active low.
- ENET_RST_N  out  1  constant 1.
- ENET_CLK  out  1  equals Clock.
- interrupt_out  out  1  ENET_INT through a 2-flop synchroniser.

Behaviour:
- All pin outputs and status outputs are registered. Pin values in a cycle are a function of the current state.
- Reset values:
  - State IDLE, cmd_ready=1.
  - WR_N=1, RD_N=1, CS_N=1, CMD=0, Drive=0, ENET_DATAw=0.
  - rd_data=0, rd_valid=0, wr_ready=0, done=0, synchroniser flops=0.
- Reset mid-operation aborts immediately to those values. No partial strobe persists.
- IDLE:
  - cmd_ready=1.
  - On accept, latch write/addr/len/delay, beat counter=len, go to IDX_SETUP.
- IDX_SETUP (SETUP_CYC cycles): CS_N=0, CMD=0, Drive=1, DATAw=addr.
- IDX_STROBE (STROBE_CYC cycles): same as IDX_SETUP, plus WR_N=0.
- IDX_RECOVER (RECOVER_CYC cycles): CS_N=0, strobes high, Drive=0.
  - Exit: beats remaining=0 -> DELAY.
  - Exit: write -> WAIT_WR.
  - Exit: read -> DAT_SETUP.
- WAIT_WR:
  - wr_ready=1; stall indefinitely while wr_valid=0.
  - On the handshake, latch wr_data and go to DAT_SETUP.
  - wr_ready is never high outside WAIT_WR.
- DAT_SETUP (SETUP_CYC cycles):
  - CMD=1, CS_N=0.
  - Write: Drive=1, DATAw=latched word.
  - Read: Drive=0.
- DAT_STROBE (STROBE_CYC cycles):
  - WR_N=0 (write) or RD_N=0 (read).
  - Read: ENET_DATAr is sampled on the last strobe cycle. rd_data/rd_valid appear the following cycle.
- DAT_RECOVER (RECOVER_CYC cycles):
  - Decrement the beat counter.
  - Remaining>0 -> WAIT_WR (write) or DAT_SETUP (read).
  - Else -> DELAY.
- DELAY:
  - Counts cmd_delay cycles; cmd_delay=0 takes 0 extra cycles, passing straight through.
  - Then done=1 for one cycle, entering IDLE.
  - cmd_ready rises in the cycle after done.
- Timing counters:
  - One shared phase counter, reloaded on each state entry.
  - Width is clog2 of the max of the timing parameters plus 1.
- Read latency, defaults:
  - Accept at cycle 0.
  - Index strobe at cycle 2.
  - Read strobe at cycle 6.
  - rd_valid at cycle 7.
  - done at cycle 9 with cmd_delay=0.
- cmd_valid while busy is ignored; it must be held until accepted.
- The beat counter never wraps: len=2^LEN_W-1 performs exactly that many beats.
- DATA_W=8: the upper ENET_DATAr bits are absent, and the index is addr[7:0].

Test Plan:
- Reset asserted asynchronously mid-DAT_STROBE of a write -> within the same cycle, WR_N=1, CS_N=1, Drive=0, cmd_ready=1 after release.
- Read cmd addr=0x28 len=1 delay=0, ENET_DATAr=0x0A46 -> DATAw=0x0028 with WR_N low at cycle 2, RD_N low at cycle 6, rd_valid/rd_data=0x0A46 at cycle 7, done at cycle 9.
- Write cmd addr=0xF8 len=4, wr_valid withheld 5 cycles before beat 3 -> exactly 4 WR_N data pulses with words in order, no strobe during the stall, wr_ready never high outside WAIT_WR.
- Index-only cmd len=0 delay=300 -> one index strobe, no data strobe, done exactly 300 cycles after the final recovery.
- SETUP_CYC=2, STROBE_CYC=3, RECOVER_CYC=1 read burst len=3 -> each RD_N low pulse is 3 cycles, preceded by 2 setup cycles, 3 rd_valid pulses.
- ENET_INT pulse -> interrupt_out follows 2 cycles later; cmd_valid held during a busy command is accepted only in the cycle after done.
